uart_digit_buffer: RTL and testbench
====================================

UART_DIGIT_BUFFER -- requirements
Module: uart_digit_buffer

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of display digits held (legal range 2..8).
REQ-002 Parameter SHIFT_MODE, default 0, selects the write mode: 0 = positional with wrap, 1 = scroll-in shift.
REQ-003 Parameter ERR_W, default 8, width of the error counter.
REQ-004 clk  input  1  system clock; all state updates on its rising edge; one clock only.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 rx_valid  input  1  single-cycle strobe, synchronous to clk: rx_data holds a new received byte.
REQ-007 rx_data  input  8  received byte, sampled only when rx_valid=1.
REQ-008 seg_bus  output  7*NUM_DIGITS  per-digit active-low segment patterns; digit i occupies bits [7i+6:7i]; bit order {g,f,e,d,c,b,a}.
REQ-009 digit_valid  output  NUM_DIGITS  bit i=1 when digit i holds a received character.
REQ-010 wr_ptr  output  3  index of the next digit to be written (positional mode); fill count saturating at NUM_DIGITS (shift mode).
REQ-011 frame_done  output  1  one-cycle pulse on completion of a frame.
REQ-012 err_cnt  output  ERR_W  count of rejected bytes, saturating.

Function
REQ-013 Accepted characters: ASCII '0'-'9', 'A'-'F' and 'a'-'f', each decoded to a 4-bit hex value.
REQ-014 Hex value segment patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-015 Blank pattern: 1111111; any digit with digit_valid=0 shows the blank pattern.
REQ-016 Clear command: byte 0x0D (CR) blanks all digits, clears digit_valid, sets wr_ptr=0, resets the frame counter, and does not change err_cnt.
REQ-017 Any other byte is rejected: err_cnt increments by 1, saturating at 2^ERR_W-1, and no other state changes.
REQ-018 All outputs are registered; the effect of a byte sampled at edge N appears at edge N+1 (1-cycle latency).
REQ-019 Positional mode: the character is written to digit wr_ptr, that digit_valid bit is set, and wr_ptr advances by 1, wrapping from NUM_DIGITS-1 to 0.
REQ-020 Positional mode frame: frame_done pulses in the same cycle the write to digit NUM_DIGITS-1 becomes visible.
REQ-021 Positional wrap: a write over an existing digit overwrites it; digit_valid bits of other digits are unchanged.
REQ-022 Shift mode: digit i takes digit i-1 for i=NUM_DIGITS-1..1, digit 0 takes the new character, and digit_valid shifts the same way with 1 entering bit 0.
REQ-023 Shift mode: the old contents of digit NUM_DIGITS-1 are discarded; wr_ptr = min(fill+1, NUM_DIGITS).
REQ-024 Shift mode frame: a frame counter counts accepted characters mod NUM_DIGITS, and frame_done pulses on each wrap to 0 (every NUM_DIGITS accepted characters).
REQ-025 frame_done is high for exactly one cycle per frame and is 0 at all other times.
REQ-026 rx_valid held high for K consecutive cycles is treated as K distinct bytes; there is no back-pressure and no byte is dropped.
REQ-027 Rejected bytes and CR do not advance the frame counter.

Reset
REQ-028 While rst=1 and on assertion: seg_bus = all 1s (all digits blank), digit_valid=0, wr_ptr=0, frame counter=0, frame_done=0, err_cnt=0.
REQ-029 Assertion of rst mid-frame discards partial contents immediately, without waiting for clk.
REQ-030 A byte with rx_valid=1 on the first edge after rst deasserts is accepted normally.

Verification
REQ-031 Positional, NUM_DIGITS=4: bytes '1','2','3','4' -> digits 0..3 = 1111001, 0100100, 0110000, 0011001; frame_done pulses once after '4'; wr_ptr=0.
REQ-032 Positional wrap: continue with '9' -> digit 0 = 0010000, digits 1..3 unchanged, and no frame_done.
REQ-033 SHIFT_MODE=1: bytes 'a','b','c','d','e' -> digits 3..0 = b,C,d,E; frame_done after 'd' only; wr_ptr=4.
REQ-034 Errors and clear: bytes 'Z',0x20,'5',0x0D -> err_cnt=2; after CR all digits are blank, digit_valid=0, wr_ptr=0.
REQ-035 ERR_W=2: send 5 invalid bytes -> err_cnt saturates at 3.
REQ-036 Reset mid-frame: after '7','8', assert rst asynchronously between clock edges -> all digits blank and wr_ptr=0 before the next edge; then '1' -> written to digit 0.

Source files
------------

// File: rtl/uart_digit_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : uart_digit_buffer
//  Purpose  : Collects hex characters arriving as UART bytes and holds them
//             as active-low 7-segment patterns for a NUM_DIGITS display.
//             Two write styles: positional with wrap (SHIFT_MODE=0) or
//             scroll-in from the right (SHIFT_MODE=1). CR clears the display
//             and any other non-hex byte is counted as an error.
//  Ports    : clk          system clock, rising edge
//             rst          asynchronous active-high reset
//             rx_valid     single-cycle strobe, rx_data holds a new byte
//             rx_data      received byte
//             seg_bus      digit i in bits [7i+6:7i], order {g,f,e,d,c,b,a}
//             digit_valid  bit i set when digit i holds a character
//             wr_ptr       next digit index (positional) / fill count (shift)
//             frame_done   one-cycle pulse when a frame completes
//             err_cnt      saturating count of rejected bytes
//  Revision : 1.0  initial release
// ============================================================================
module uart_digit_buffer #(
  parameter int NUM_DIGITS = 4,
  parameter int SHIFT_MODE = 0,
  parameter int ERR_W      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  output logic [7*NUM_DIGITS-1:0] seg_bus,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [2:0]              wr_ptr,
  output logic                    frame_done,
  output logic [ERR_W-1:0]        err_cnt
);

  localparam logic [7:0] CR_BYTE  = 8'h0D;
  localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);
  localparam logic [3:0] FULL_CNT = 4'(NUM_DIGITS);

  logic       is_hex;
  logic       is_cr;
  logic [3:0] hex_val;
  logic [6:0] seg_new;
  logic [3:0] fill;       // shift-mode fill count, one bit wider than wr_ptr
  logic [3:0] fill_nxt;
  logic [2:0] frame_cnt;  // shift-mode accepted characters mod NUM_DIGITS

  // ASCII to hex nibble: 'A'..'F' and 'a'..'f' both carry 1..6 in the low nibble.
  always_comb begin
    is_hex  = 1'b0;
    hex_val = 4'h0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      is_hex  = 1'b1;
      hex_val = rx_data[3:0];
    end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                 (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
      is_hex  = 1'b1;
      hex_val = rx_data[3:0] + 4'd9;
    end
  end

  assign is_cr = (rx_data == CR_BYTE);

  always_comb begin
    seg_new = 7'b1111111;
    case (hex_val)
      4'h0: seg_new = 7'b1000000;
      4'h1: seg_new = 7'b1111001;
      4'h2: seg_new = 7'b0100100;
      4'h3: seg_new = 7'b0110000;
      4'h4: seg_new = 7'b0011001;
      4'h5: seg_new = 7'b0010010;
      4'h6: seg_new = 7'b0000010;
      4'h7: seg_new = 7'b1111000;
      4'h8: seg_new = 7'b0000000;
      4'h9: seg_new = 7'b0010000;
      4'hA: seg_new = 7'b0001000;
      4'hB: seg_new = 7'b0000011;
      4'hC: seg_new = 7'b1000110;
      4'hD: seg_new = 7'b0100001;
      4'hE: seg_new = 7'b0000110;
      4'hF: seg_new = 7'b0001110;
      default: seg_new = 7'b1111111;
    endcase
  end

  // Fill count saturates at NUM_DIGITS. With NUM_DIGITS=8 the full count
  // does not fit the 3-bit wr_ptr port and reads back as 0 there.
  assign fill_nxt = (fill == FULL_CNT) ? fill : fill + 4'd1;

  // Segment patterns are stored directly (blank for empty digits) so that
  // seg_bus itself is the register driving the port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_bus     <= '1;
      digit_valid <= '0;
      wr_ptr      <= '0;
      fill        <= '0;
      frame_cnt   <= '0;
      frame_done  <= 1'b0;
      err_cnt     <= '0;
    end else begin
      frame_done <= 1'b0;
      if (rx_valid) begin
        if (is_cr) begin
          seg_bus     <= '1;
          digit_valid <= '0;
          wr_ptr      <= '0;
          fill        <= '0;
          frame_cnt   <= '0;
        end else if (!is_hex) begin
          if (err_cnt != '1) begin
            err_cnt <= err_cnt + ERR_W'(1);
          end
        end else if (SHIFT_MODE != 0) begin
          seg_bus     <= {seg_bus[7*NUM_DIGITS-8:0], seg_new};
          digit_valid <= {digit_valid[NUM_DIGITS-2:0], 1'b1};
          fill        <= fill_nxt;
          wr_ptr      <= fill_nxt[2:0];
          if (frame_cnt == LAST_IDX) begin
            frame_cnt  <= 3'd0;
            frame_done <= 1'b1;
          end else begin
            frame_cnt <= frame_cnt + 3'd1;
          end
        end else begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (wr_ptr == 3'(i)) begin
              seg_bus[7*i +: 7] <= seg_new;
              digit_valid[i]    <= 1'b1;
            end
          end
          // In positional mode the write pointer doubles as the frame position.
          if (wr_ptr == LAST_IDX) begin
            wr_ptr     <= 3'd0;
            frame_done <= 1'b1;
          end else begin
            wr_ptr <= wr_ptr + 3'd1;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_digit_buffer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_uart_digit_buffer
//  Purpose  : Self-checking bench for uart_digit_buffer. Three instances
//             (positional N=4, shift N=4, positional N=3 with 2-bit error
//             counter) share one byte stream and are compared each cycle
//             against a digit-array reference model, plus literal checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_digit_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;

  always #5 clk = ~clk;

  // Instance outputs
  logic [27:0] seg0, seg1;
  logic [20:0] seg2;
  logic [3:0]  val0, val1;
  logic [2:0]  val2;
  logic [2:0]  ptr0, ptr1, ptr2;
  logic        fd0, fd1, fd2;
  logic [7:0]  err0, err1;
  logic [1:0]  err2;

  uart_digit_buffer #(.NUM_DIGITS(4), .SHIFT_MODE(0), .ERR_W(8)) u_pos (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .seg_bus(seg0), .digit_valid(val0), .wr_ptr(ptr0), .frame_done(fd0), .err_cnt(err0));

  uart_digit_buffer #(.NUM_DIGITS(4), .SHIFT_MODE(1), .ERR_W(8)) u_shf (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .seg_bus(seg1), .digit_valid(val1), .wr_ptr(ptr1), .frame_done(fd1), .err_cnt(err1));

  uart_digit_buffer #(.NUM_DIGITS(3), .SHIFT_MODE(0), .ERR_W(2)) u_err (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .seg_bus(seg2), .digit_valid(val2), .wr_ptr(ptr2), .frame_done(fd2), .err_cnt(err2));

  logic [55:0] d_seg [3];
  logic [7:0]  d_val [3];
  logic [2:0]  d_ptr [3];
  logic        d_fd  [3];
  logic [7:0]  d_err [3];

  assign d_seg[0] = 56'(seg0);
  assign d_seg[1] = 56'(seg1);
  assign d_seg[2] = 56'(seg2);
  assign d_val[0] = 8'(val0);
  assign d_val[1] = 8'(val1);
  assign d_val[2] = 8'(val2);
  assign d_ptr[0] = ptr0;
  assign d_ptr[1] = ptr1;
  assign d_ptr[2] = ptr2;
  assign d_fd[0]  = fd0;
  assign d_fd[1]  = fd1;
  assign d_fd[2]  = fd2;
  assign d_err[0] = err0;
  assign d_err[1] = err1;
  assign d_err[2] = 8'(err2);

  // ---------------------------------------------------------------- model
  int m_hex [3][8];
  bit m_val [3][8];
  int m_ptr [3];
  int m_acc [3];
  bit m_fd  [3];
  int m_err [3];

  function automatic int cfg_n(int j);
    return (j == 2) ? 3 : 4;
  endfunction
  function automatic bit cfg_shift(int j);
    return (j == 1);
  endfunction
  function automatic int cfg_emax(int j);
    return (j == 2) ? 3 : 255;
  endfunction

  function automatic int hexval(logic [7:0] b);
    if (b >= "0" && b <= "9") return int'(b) - 48;
    if (b >= "A" && b <= "F") return int'(b) - 55;
    if (b >= "a" && b <= "f") return int'(b) - 87;
    return -1;
  endfunction

  function automatic logic [6:0] seg_tab(int h);
    case (h)
      0: return 7'b1000000;  1: return 7'b1111001;
      2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000;
      10: return 7'b0001000; 11: return 7'b0000011;
      12: return 7'b1000110; 13: return 7'b0100001;
      14: return 7'b0000110; default: return 7'b0001110;
    endcase
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < 8; i++) begin
        m_hex[j][i] = 0;
        m_val[j][i] = 1'b0;
      end
      m_ptr[j] = 0; m_acc[j] = 0; m_fd[j] = 1'b0; m_err[j] = 0;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    int h;
    int n;
    h = hexval(b);
    for (int j = 0; j < 3; j++) begin
      n = cfg_n(j);
      m_fd[j] = 1'b0;
      if (b == 8'h0D) begin
        for (int i = 0; i < 8; i++) m_val[j][i] = 1'b0;
        m_ptr[j] = 0;
        m_acc[j] = 0;
      end else if (h < 0) begin
        if (m_err[j] < cfg_emax(j)) m_err[j]++;
      end else if (!cfg_shift(j)) begin
        m_hex[j][m_ptr[j]] = h;
        m_val[j][m_ptr[j]] = 1'b1;
        m_fd[j]  = (m_ptr[j] == n - 1);
        m_ptr[j] = (m_ptr[j] + 1) % n;
      end else begin
        for (int i = n - 1; i >= 1; i--) begin
          m_hex[j][i] = m_hex[j][i-1];
          m_val[j][i] = m_val[j][i-1];
        end
        m_hex[j][0] = h;
        m_val[j][0] = 1'b1;
        m_acc[j] = (m_acc[j] + 1) % n;
        m_fd[j]  = (m_acc[j] == 0);
        m_ptr[j] = (m_ptr[j] < n) ? m_ptr[j] + 1 : n;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else if (rx_valid) model_byte(rx_data);
    else for (int j = 0; j < 3; j++) m_fd[j] = 1'b0;
  end

  function automatic logic [55:0] exp_seg(int j);
    logic [55:0] v;
    v = '0;
    for (int i = 0; i < cfg_n(j); i++)
      v[7*i +: 7] = m_val[j][i] ? seg_tab(m_hex[j][i]) : 7'b1111111;
    return v;
  endfunction

  function automatic logic [7:0] exp_val(int j);
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < cfg_n(j); i++) v[i] = m_val[j][i];
    return v;
  endfunction

  // ---------------------------------------------------------------- checks
  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;
  int fd1_cnt  = 0;

  task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d got=%h expected=%h t=%0t", name, inst, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int j = 0; j < 3; j++) begin
        chk("seg_bus", j, 64'(d_seg[j]), 64'(exp_seg(j)));
        chk("digit_valid", j, 64'(d_val[j]), 64'(exp_val(j)));
        chk("wr_ptr", j, 64'(d_ptr[j]), 64'(m_ptr[j]));
        chk("frame_done", j, 64'(d_fd[j]), 64'(m_fd[j]));
        chk("err_cnt", j, 64'(d_err[j]), 64'(m_err[j]));
      end
      if (fd1) fd1_cnt++;
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
  endtask

  task automatic idle();
    @(negedge clk); #1;
    rx_valid = 1'b0;
  endtask

  string hexchars = "0123456789ABCDEFabcdef";

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_seg", 0, 64'(seg0), 64'h0FFFFFFF);
    chk("rst_valid", 0, 64'(val0), 64'h0);
    chk("rst_ptr", 0, 64'(ptr0), 64'h0);
    chk("rst_fd", 0, 64'(fd0), 64'h0);
    chk("rst_err", 0, 64'(err0), 64'h0);
    chk_en = 1'b1;

    // Byte present on the first edge after reset release must be taken.
    rx_valid = 1'b1; rx_data = "1"; rst = 1'b0;
    send("2"); send("3"); send("4"); idle();
    chk("pos_1234_seg", 0, 64'(seg0), 64'({7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001}));
    chk("pos_1234_fd", 0, 64'(fd0), 64'h1);
    chk("pos_1234_ptr", 0, 64'(ptr0), 64'h0);
    chk("shf_1234_seg", 1, 64'(seg1), 64'({7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}));
    chk("shf_1234_ptr", 1, 64'(ptr1), 64'h4);

    send("9"); idle();
    chk("pos_wrap_seg", 0, 64'(seg0), 64'({7'b0011001, 7'b0110000, 7'b0100100, 7'b0010000}));
    chk("pos_wrap_fd", 0, 64'(fd0), 64'h0);
    chk("pos_wrap_ptr", 0, 64'(ptr0), 64'h1);

    send(8'h0D); idle();
    fd1_cnt = 0;
    send("a"); send("b"); send("c"); send("d"); send("e"); idle();
    chk("shf_abcde_seg", 1, 64'(seg1), 64'({7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110}));
    chk("shf_abcde_ptr", 1, 64'(ptr1), 64'h4);
    chk("shf_abcde_fd_pulses", 1, 64'(fd1_cnt), 64'h1);

    send(8'h0D); send("Z"); send(8'h20); send("5"); send(8'h0D); idle();
    chk("err_clr_err", 0, 64'(err0), 64'h2);
    chk("err_clr_seg", 0, 64'(seg0), 64'h0FFFFFFF);
    chk("err_clr_valid", 0, 64'(val0), 64'h0);
    chk("err_clr_ptr", 0, 64'(ptr0), 64'h0);

    repeat (5) send("G");
    idle();
    chk("err_sat", 2, 64'(err2), 64'h3);
    chk("err_nosat", 0, 64'(err0), 64'h7);

    // Asynchronous reset between edges, checked before the next edge.
    send("7"); send("8"); idle();
    rst = 1'b1;
    #1;
    chk("async_rst_seg", 0, 64'(seg0), 64'h0FFFFFFF);
    chk("async_rst_ptr", 0, 64'(ptr0), 64'h0);
    chk("async_rst_valid", 0, 64'(val0), 64'h0);
    #1;
    rst = 1'b0;
    send("1"); idle();
    chk("post_rst_seg", 0, 64'(seg0), 64'({21'h1FFFFF, 7'b1111001}));
    chk("post_rst_ptr", 0, 64'(ptr0), 64'h1);
    chk("post_rst_valid", 0, 64'(val0), 64'h1);

    // Randomized traffic, including back-to-back strobes and rare resets.
    for (int k = 0; k < 3000; k++) begin
      int r;
      @(negedge clk); #1;
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        #2;
        rst = 1'b0;
      end
      rx_valid = ($urandom_range(0, 3) != 0);
      r = int'($urandom_range(0, 19));
      if (r == 0)      rx_data = 8'h0D;
      else if (r < 15) rx_data = hexchars[$urandom_range(0, 21)];
      else             rx_data = 8'($urandom_range(0, 255));
    end
    idle();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
